// File: rtl/alu_seq_control_if.sv
// rtl/alu_seq_control_if.sv - strobe and instruction bundle between control unit and datapath
interface alu_seq_control_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   Run;
  logic [31:0]            IR;
  logic                   PCout;
  logic                   ZLOout;
  logic                   MDRout;
  logic                   MARin;
  logic                   Zin;
  logic                   PCin;
  logic                   MDRin;
  logic                   IRin;
  logic                   Yin;
  logic                   IncrementPC;
  logic                   Read;
  logic [4:0]             ALUControl;
  logic [15:0]            Rin;
  logic [15:0]            Rout;
  logic                   Busy;
  logic                   Halted;
  logic                   Illegal;
  logic [COUNT_WIDTH-1:0] InstrCount;

  // master is the control unit; slave is the datapath side
  modport master (
    input  Run, IR,
    output PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncrementPC, Read, ALUControl, Rin, Rout, Busy, Halted, Illegal,
           InstrCount
  );

  modport slave (
    output Run, IR,
    input  PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncrementPC, Read, ALUControl, Rin, Rout, Busy, Halted, Illegal,
           InstrCount
  );
endinterface

// File: rtl/alu_seq_control.sv
// rtl/alu_seq_control.sv - hardwired fetch/execute sequencer for the phase-1 datapath
module alu_seq_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Resetn,
  alu_seq_control_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, T3, T4, T5, HALT
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] count;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_nop, is_halt;
  logic       unused_ir;

  assign op        = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];

  assign is_alu  = (op >= 5'b00011) && (op <= 5'b01011);
  assign is_nop  = (op == 5'b11010);
  assign is_halt = (op == 5'b11011);

  // Run only matters at instruction boundaries, so a mid-instruction drop finishes the instruction
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: state <= bus.Run ? T0 : IDLE;
        T0:   state <= T1;
        T1:   state <= T2;
        T2:   state <= T3;
        T3: begin
          if (is_alu)       state <= T4;
          else if (is_halt) state <= HALT;
          else              state <= bus.Run ? T0 : IDLE;
        end
        T4:   state <= T5;
        T5: begin
          count <= count + COUNT_WIDTH'(1);
          state <= bus.Run ? T0 : IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // T3-T5 strobes depend on IR fields, which are stable from the first T3 cycle
  always_comb begin
    bus.PCout       = 1'b0;
    bus.ZLOout      = 1'b0;
    bus.MDRout      = 1'b0;
    bus.MARin       = 1'b0;
    bus.Zin         = 1'b0;
    bus.PCin        = 1'b0;
    bus.MDRin       = 1'b0;
    bus.IRin        = 1'b0;
    bus.Yin         = 1'b0;
    bus.IncrementPC = 1'b0;
    bus.Read        = 1'b0;
    bus.ALUControl  = 5'b00000;
    bus.Rin         = 16'h0000;
    bus.Rout        = 16'h0000;
    bus.Illegal     = 1'b0;
    bus.Busy        = (state != IDLE) && (state != HALT);
    bus.Halted      = (state == HALT);
    bus.InstrCount  = count;
    case (state)
      T0: begin
        bus.PCout       = 1'b1;
        bus.MARin       = 1'b1;
        bus.IncrementPC = 1'b1;
        bus.Zin         = 1'b1;
      end
      T1: begin
        bus.ZLOout = 1'b1;
        bus.PCin   = 1'b1;
        bus.Read   = 1'b1;
        bus.MDRin  = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          bus.Rout = 16'h0001 << rb;
          bus.Yin  = 1'b1;
        end else if (!is_nop && !is_halt) begin
          bus.Illegal = 1'b1;
        end
      end
      T4: begin
        bus.Rout       = 16'h0001 << rc;
        bus.Zin        = 1'b1;
        bus.ALUControl = op;
      end
      T5: begin
        bus.ZLOout = 1'b1;
        bus.Rin    = 16'h0001 << ra;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_control.sv
// tb/tb_alu_seq_control.sv - randomized check of alu_seq_control against a per-instruction cycle-list model
module tb_alu_seq_control;

  localparam int CW = 4;

  logic Clock = 1'b0;
  logic Resetn;

  alu_seq_control_if #(.COUNT_WIDTH(CW)) bus ();

  alu_seq_control #(.COUNT_WIDTH(CW)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        pc_out, zlo_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read;
    logic [4:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        busy, halted, illegal;
  } outs_t;

  int n_checks = 0;
  int n_fail   = 0;
  int model_count;
  bit at_idle;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic outs_t observe();
    outs_t o;
    o.pc_out  = bus.PCout;
    o.zlo_out = bus.ZLOout;
    o.mdr_out = bus.MDRout;
    o.mar_in  = bus.MARin;
    o.z_in    = bus.Zin;
    o.pc_in   = bus.PCin;
    o.mdr_in  = bus.MDRin;
    o.ir_in   = bus.IRin;
    o.y_in    = bus.Yin;
    o.inc_pc  = bus.IncrementPC;
    o.read    = bus.Read;
    o.alu     = bus.ALUControl;
    o.rin     = bus.Rin;
    o.rout    = bus.Rout;
    o.busy    = bus.Busy;
    o.halted  = bus.Halted;
    o.illegal = bus.Illegal;
    return o;
  endfunction

  task automatic cycle(input outs_t exp, input bit rv, input string tag);
    bus.Run = rv;
    @(negedge Clock);
    check({tag, " strobes"}, 64'(observe()), 64'(exp));
    check({tag, " count"}, 64'(bus.InstrCount), 64'(model_count));
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    check("reset strobes", 64'(observe()), 64'd0);
    check("reset count", 64'(bus.InstrCount), 64'd0);
    @(posedge Clock);
    #1;
    Resetn      = 1'b1;
    model_count = 0;
    at_idle     = 1'b1;
  endtask

  task automatic idle(input int n);
    outs_t z;
    z = '0;
    repeat (n) cycle(z, 1'b0, "idle");
  endtask

  // Expected per-cycle strobes for one instruction; abort=1 pulls Resetn low during T4
  task automatic run_instr(input logic [31:0] ir, input bit run_last, input bit abort);
    outs_t      q[$];
    outs_t      o;
    logic [4:0] op;
    bit         alu, nop, hlt, rv;
    int         t4_idx;
    op  = ir[31:27];
    alu = (op >= 5'd3) && (op <= 5'd11);
    nop = (op == 5'd26);
    hlt = (op == 5'd27);
    bus.IR = ir;
    if (at_idle) begin o = '0; q.push_back(o); end
    o = '0; o.busy = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1; q.push_back(o);
    o = '0; o.busy = 1; o.zlo_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1; q.push_back(o);
    o = '0; o.busy = 1; o.mdr_out = 1; o.ir_in = 1; q.push_back(o);
    o = '0; o.busy = 1;
    if (alu) begin
      o.rout = 16'h0001 << ir[22:19];
      o.y_in = 1;
    end else if (!nop && !hlt) begin
      o.illegal = 1;
    end
    q.push_back(o);
    t4_idx = q.size();
    if (alu) begin
      o = '0; o.busy = 1; o.rout = 16'h0001 << ir[18:15]; o.z_in = 1; o.alu = op; q.push_back(o);
      o = '0; o.busy = 1; o.zlo_out = 1; o.rin = 16'h0001 << ir[26:23]; q.push_back(o);
    end
    for (int i = 0; i < q.size(); i++) begin
      if (abort && alu && i == t4_idx) begin
        bus.Run = 1'b1;
        #2;
        check("pre-abort T4", 64'(observe()), 64'(q[i]));
        Resetn = 1'b0;
        #1;
        check("abort strobes", 64'(observe()), 64'd0);
        check("abort count", 64'(bus.InstrCount), 64'd0);
        @(posedge Clock);
        #1;
        Resetn      = 1'b1;
        model_count = 0;
        at_idle     = 1'b1;
        return;
      end
      if (i == q.size() - 1)      rv = run_last;
      else if (at_idle && i == 0) rv = 1'b1;
      else                        rv = 1'($urandom_range(0, 1));
      cycle(q[i], rv, $sformatf("op%0d c%0d", op, i));
    end
    if (alu) model_count = (model_count + 1) % (1 << CW);
    at_idle = !run_last;
  endtask

  initial begin
    outs_t      h;
    logic [4:0] op;
    logic [31:0] ir;
    int         r;
    Resetn = 1'b0;
    bus.Run = 1'b0;
    bus.IR  = 32'h0;
    model_count = 0;
    at_idle     = 1'b1;
    do_reset();
    idle(5);

    run_instr(32'h18918000, 1'b1, 1'b0);
    run_instr(32'h28918000, 1'b0, 1'b0);
    idle(2);
    run_instr(32'hD0000000, 1'b1, 1'b0);
    run_instr(32'h00000000, 1'b0, 1'b0);
    idle(1);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        op = 5'($urandom_range(3, 11));
      end else if (r == 6) begin
        op = 5'd26;
      end else begin
        do op = 5'($urandom_range(0, 31)); while ((op >= 5'd3 && op <= 5'd11) || op == 5'd26 || op == 5'd27);
      end
      ir = $urandom;
      ir[31:27] = op;
      run_instr(ir, ($urandom_range(0, 3) != 0), 1'b0);
      if (at_idle) idle($urandom_range(0, 2));
    end

    run_instr(32'h18918000, 1'b0, 1'b0);
    idle(1);
    run_instr(32'h18918000, 1'b1, 1'b1);
    idle(2);

    run_instr(32'h18918000, 1'b1, 1'b0);
    run_instr(32'hD8000000, 1'b1, 1'b0);
    h = '0;
    h.halted = 1'b1;
    for (int k = 0; k < 10; k++) cycle(h, 1'b1, "halt hold");
    do_reset();
    idle(2);
    run_instr(32'h30918000, 1'b0, 1'b0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_control.md
# alu_seq_control

Hardwired control unit for the phase-1 datapath. It replaces the hand-timed bench stimulus with a state machine. It sequences instruction fetch (T0–T2) and three-register ALU execution (T3–T5), and drives every bus-source, register-load, memory and ALU-select strobe. It decodes the Ra/Rb/Rc fields of IR into one-hot register strobes, and counts retired instructions.

## Interface
- COUNT_WIDTH, 16, width of the retired-instruction counter.
- Clock  in  1  system clock; all state changes on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  level; start/continue fetching instructions.
- IR  in  32  current instruction register contents (datapath IR output).
- PCout, ZLOout, MDRout  out  1 each  bus-source enables.
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load enables.
- IncrementPC  out  1  ALU performs PC+1 on bus value.
- Read  out  1  memory read strobe into MDR.
- ALUControl  out  5  ALU operation select.
- Rin  out  16  one-hot general register load enables, R0..R15.
- Rout  out  16  one-hot general register bus-source enables.
- Busy  out  1  high in any state other than IDLE and HALT.
- Halted  out  1  high in HALT.
- Illegal  out  1  high during a T3 holding an unsupported opcode.
- InstrCount  out  COUNT_WIDTH  retired ALU instructions, wraps modulo 2^COUNT_WIDTH.

## Operation
- IR fields: op = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- Supported ALU opcodes are 00011 (add) through 01011 (shl), inclusive. 11010 is nop and 11011 is halt. Every other opcode is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. Outputs are a Moore decode of the state plus the IR fields.
- Every output not listed for a state is 0 in that state.
- IDLE: all strobes 0. Next state is T0 if Run, else IDLE.
- T0: PCout, MARin, IncrementPC, Zin. Next state T1.
- T1: ZLOout, PCin, Read, MDRin. Next state T2.
- T2: MDRout, IRin. Next state T3. IR is valid from the first T3 cycle onward.
- T3 with an ALU op: Rout[Rb], Yin. Next state T4.
- T3 with nop: no strobes. Next state T0 if Run, else IDLE.
- T3 with halt: no strobes. Next state HALT.
- T3 with an illegal op: Illegal = 1, no strobes. Next state T0 if Run, else IDLE.
- T4: Rout[Rc], Zin, ALUControl = op. Next state T5.
- T5: ZLOout, Rin[Ra]. InstrCount increments on exit. Next state T0 if Run, else IDLE.
- HALT: absorbing. Halted = 1, all strobes 0. Only Resetn leaves it.
- ALUControl is 5'b00000 in every state except T4.
- Rin and Rout are all-zero outside T5 and T3/T4 respectively. They are never multi-hot.
- Run is sampled only at IDLE, T3 (nop/illegal) and T5. Deasserting Run mid-instruction completes that instruction, then goes to IDLE.
- nop, halt and illegal do not increment InstrCount.

## Timing
- Reset (Resetn low, asynchronous):
  - state goes to IDLE immediately.
  - every output is 0, including InstrCount.
  - Release of reset is synchronous to Clock; the first possible T0 is the first edge after release with Run = 1.
- ALU instruction: exactly 6 cycles, T0 through T5. Back-to-back instructions with Run held high have no gap cycle.
- nop/illegal: 4 cycles (T0–T3).
- Halt: HALT is entered at the edge after T3.
- Counter wrap: 2^COUNT_WIDTH−1 goes to 0 on the next retirement.
- Reset mid-instruction: the instruction is abandoned with no partial count, and all strobes drop asynchronously.
- Outputs are glitch-free relative to the clock edge. The datapath captures on the next rising edge.

## Test plan
- Reset, then hold Run = 0 for 5 cycles -> state stays IDLE; all outputs 0; Busy = 0; InstrCount = 0.
- Run = 1 with IR = 0x18918000 (add R1,R2,R3), then check each state:
  - T0: PCout = MARin = IncrementPC = Zin = 1.
  - T3: Rout = 0x0004, Yin = 1.
  - T4: Rout = 0x0008, ALUControl = 00011, Zin = 1.
  - T5: Rin = 0x0002, ZLOout = 1.
  - After T5, InstrCount = 1.
- IR = 0x28918000 (and) back-to-back with Run high -> T5 goes directly to T0, ALUControl = 00101 in T4, InstrCount = 2 after two instructions.
- IR = 0xD0000000 (nop) then IR = 0x00000000 (illegal) -> each takes 4 cycles. Illegal pulses for exactly one cycle on the second instruction. InstrCount is unchanged.
- IR = 0xD8000000 (halt) -> HALT is reached after T3, with Halted = 1 and Busy = 0. It stays there for 10 cycles despite Run = 1, and leaves only on Resetn.
- Drop Run during T4, and separately assert Resetn low during T4:
  - Run drop -> T5 completes, then IDLE.
  - Reset -> outputs go to 0 immediately with no retirement counted.
